// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: mixer state encoding, accumulator sizing
// and the standard-width sample limits used by oscillators and output stage.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2
  } mix_state_t;

  localparam int STD_SIG_W = 16;
  localparam logic signed [STD_SIG_W-1:0] SIG_MAX = 16'sh7FFF;
  localparam logic signed [STD_SIG_W-1:0] SIG_MIN = 16'sh8000;

  // Wide enough that N_CH full-scale products summed can never wrap.
  function automatic int acc_width(input int n_ch, input int sig_w, input int gain_w);
    return sig_w + gain_w + $clog2(n_ch) + 1;
  endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational arithmetic right shift followed by saturation from IN_W
// down to OUT_W signed bits (floor rounding, clamps to the OUT_W range).
module sat_shift #(
  parameter int IN_W  = 27,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [IN_W-1:0] shifted;

  // Fits when every bit above the output sign bit equals it.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W-1:0] v);
    logic [IN_W-OUT_W:0] top;
    top = v[IN_W-1:OUT_W-1];
    if (&top || ~|top) return v[OUT_W-1:0];
    return {v[IN_W-1], {(OUT_W-1){~v[IN_W-1]}}};
  endfunction

  assign shifted = din >>> SHIFT;
  assign dout    = saturate(shifted);

endmodule

// File: rtl/voice_mixer.sv
// N-channel signed voice mixer: one multiply-accumulate per clock, then
// shift/saturate. Optional peak meter enabled by VOICE_MIXER_PEAK_EN.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int SIG_W     = 16,
  parameter int GAIN_W    = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_stb,
  input  logic [N_CH*SIG_W-1:0]    ch_sig,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH*GAIN_W-1:0]   ch_gain,
  input  logic                     clr_overrun,
  output logic [SIG_W-1:0]         sig,
  output logic                     sig_valid,
  output logic                     busy,
  output logic                     overrun
`ifdef VOICE_MIXER_PEAK_EN
  ,
  input  logic                     peak_clr,
  output logic [SIG_W-1:0]         peak
`endif
);

  localparam int ACC_W  = acc_width(N_CH, SIG_W, GAIN_W);
  localparam int PROD_W = SIG_W + GAIN_W + 1;
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SHIFT  = GAIN_W - 1 + OUT_SHIFT;

  mix_state_t               state;
  logic [IDX_W-1:0]         idx;
  logic signed [SIG_W-1:0]  smp_p0 [N_CH];
  logic [GAIN_W-1:0]        gain_p0 [N_CH];
  logic [N_CH-1:0]          en_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  term_p1;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [SIG_W-1:0]  sat_p1;
  logic signed [SIG_W-1:0]  sat_p2;
  logic                     vld_p2;
  logic                     start;

  assign start = sample_stb && (state == IDLE);

  // Stage p0: input snapshot, frozen for the whole mix
  always_ff @(posedge clk) begin
    if (start) begin
      for (int k = 0; k < N_CH; k++) begin
        smp_p0[k]  <= ch_sig[k*SIG_W +: SIG_W];
        gain_p0[k] <= ch_gain[k*GAIN_W +: GAIN_W];
      end
      en_p0 <= ch_en;
    end
  end

  // Stage p1: one channel product per clock into the accumulator
  always_comb begin
    prod_p1 = PROD_W'(smp_p0[idx]) * PROD_W'($signed({1'b0, gain_p0[idx]}));
    term_p1 = en_p0[idx] ? ACC_W'(prod_p1) : '0;
  end

  sat_shift #(
    .IN_W  (ACC_W),
    .OUT_W (SIG_W),
    .SHIFT (SHIFT)
  ) u_scale (
    .din  (acc_p1),
    .dout (sat_p1)
  );

  // Stage p2: scaled result held one cycle before it is published
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc_p1    <= '0;
      sat_p2    <= '0;
      vld_p2    <= 1'b0;
      sig       <= '0;
      sig_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sig_valid <= vld_p2;
      vld_p2    <= 1'b0;
      if (vld_p2) sig <= sat_p2;

      if (sample_stb && (state != IDLE)) overrun <= 1'b1;
      else if (clr_overrun)              overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_stb) begin
            acc_p1 <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ACC;
          end
        end
        ACC: begin
          acc_p1 <= acc_p1 + term_p1;
          if (idx == IDX_W'(N_CH - 1)) state <= SCALE;
          else                         idx   <= idx + 1'b1;
        end
        SCALE: begin
          sat_p2 <= sat_p1;
          vld_p2 <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VOICE_MIXER_PEAK_EN
  logic signed [SIG_W:0]   mag_in;
  logic signed [SIG_W-1:0] mag;

  always_comb begin
    mag_in = sat_p2[SIG_W-1] ? -((SIG_W+1)'(sat_p2)) : (SIG_W+1)'(sat_p2);
  end

  // Magnitude of the most negative sample clamps to the positive limit.
  sat_shift #(
    .IN_W  (SIG_W + 1),
    .OUT_W (SIG_W),
    .SHIFT (0)
  ) u_mag (
    .din  (mag_in),
    .dout (mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (vld_p2 && (peak_clr || ($unsigned(mag) > peak))) begin
      peak <= mag;
    end else if (peak_clr) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Directed plus randomised checks of voice_mixer against an arithmetic
// reference mix (N_CH=4, SIG_W=16, GAIN_W=8, OUT_SHIFT=0).
module tb_voice_mixer;

  typedef int arr4_t [4];

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_stb;
  logic [63:0] ch_sig;
  logic [3:0]  ch_en;
  logic [31:0] ch_gain;
  logic        clr_overrun;
  logic [15:0] sig;
  logic        sig_valid;
  logic        busy;
  logic        overrun;
`ifdef VOICE_MIXER_PEAK_EN
  logic        peak_clr;
  logic [15:0] peak;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  voice_mixer #(
    .N_CH      (4),
    .SIG_W     (16),
    .GAIN_W    (8),
    .OUT_SHIFT (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_stb  (sample_stb),
    .ch_sig      (ch_sig),
    .ch_en       (ch_en),
    .ch_gain     (ch_gain),
    .clr_overrun (clr_overrun),
    .sig         (sig),
    .sig_valid   (sig_valid),
    .busy        (busy),
    .overrun     (overrun)
`ifdef VOICE_MIXER_PEAK_EN
    ,
    .peak_clr    (peak_clr),
    .peak        (peak)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of enabled sample*gain, divided by unity with floor, clamped.
  function automatic int model(input arr4_t s, input logic [3:0] en, input arr4_t g);
    longint acc = 0;
    longint t;
    for (int k = 0; k < 4; k++)
      if (en[k]) acc += longint'(s[k]) * longint'(g[k]);
    if (acc >= 0) t = acc / 128;
    else          t = -((-acc + 127) / 128);
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  task automatic load(input arr4_t s, input logic [3:0] en, input arr4_t g);
    for (int k = 0; k < 4; k++) begin
      ch_sig[k*16 +: 16] = 16'(s[k]);
      ch_gain[k*8 +: 8]  = 8'(g[k]);
    end
    ch_en = en;
  endtask

  task automatic strobe();
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!sig_valid && lat < 20);
  endtask

  task automatic count_valid(input int n, output int cnt, output int last);
    cnt  = 0;
    last = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (sig_valid) begin
        cnt++;
        last = int'($signed(sig));
      end
    end
  endtask

  task automatic run_mix(input string tag, input arr4_t s, input logic [3:0] en,
                         input arr4_t g, input int exp);
    int lat;
    load(s, en, g);
    strobe();
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 6);
    chk({tag, "_sig"}, $signed(sig), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish before 200000");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, busy_cnt, cnt, last, exp;
    arr4_t s, g;
    logic [3:0] en;

    rst = 1'b1; sample_stb = 1'b0; clr_overrun = 1'b0;
    ch_sig = '0; ch_en = '0; ch_gain = '0;
`ifdef VOICE_MIXER_PEAK_EN
    peak_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sig", $signed(sig), 0);
    chk("rst_valid", sig_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
`ifdef VOICE_MIXER_PEAK_EN
    chk("rst_peak", peak, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // First mix: latency, busy window, pulse width
    load('{1000, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0});
    strobe();
    chk("busy_after_strobe", busy, 1);
    lat = 0; busy_cnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end while (!sig_valid && lat < 20);
    chk("first_lat", lat, 6);
    chk("first_sig", $signed(sig), 1000);
    chk("busy_cycles", busy_cnt, 4);
    chk("busy_low_at_valid", busy, 0);
    @(posedge clk); #1;
    chk("valid_one_cycle", sig_valid, 0);
    chk("sig_held", $signed(sig), 1000);

    run_mix("sat_pos", '{20000, 20000, 20000, 20000}, 4'b1111, '{128, 128, 128, 128}, 32767);
    run_mix("sat_neg", '{-30000, -30000, -30000, -30000}, 4'b1111, '{128, 128, 128, 128}, -32768);
    run_mix("half", '{1000, 0, 0, 0}, 4'b0001, '{64, 0, 0, 0}, 500);
    run_mix("floor", '{-1, 0, 0, 0}, 4'b0001, '{64, 0, 0, 0}, -1);
    run_mix("max_gain", '{1000, 0, 0, 0}, 4'b0001, '{255, 0, 0, 0}, 1992);
    run_mix("all_dis", '{5000, 6000, 7000, 8000}, 4'b0000, '{128, 128, 128, 128}, 0);
    run_mix("zero_gain", '{5000, 6000, 7000, 8000}, 4'b1111, '{0, 0, 0, 0}, 0);
    run_mix("en_mask", '{1000, 2000, 3000, 4000}, 4'b1010, '{128, 128, 128, 64}, 4000);

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 4; k++) begin
        s[k] = int'($urandom_range(0, 65535)) - 32768;
        g[k] = int'($urandom_range(0, 255));
      end
      en = 4'($urandom);
      if (it < 4) for (int k = 0; k < 4; k++) s[k] = s[k] / 8;
      run_mix($sformatf("rand%0d", it), s, en, g, model(s, en, g));
    end

    // Strobe while busy is dropped and flags overrun
    load('{1000, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0});
    strobe();
    @(posedge clk); #1;
    load('{3000, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0});
    strobe();
    chk("overrun_set", overrun, 1);
    count_valid(12, cnt, last);
    chk("overrun_one_valid", cnt, 1);
    chk("overrun_sig", last, 1000);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    chk("overrun_clr", overrun, 0);

    // Set beats clear when they coincide
    strobe();
    clr_overrun = 1'b1;
    sample_stb  = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    sample_stb  = 1'b0;
    chk("overrun_set_wins", overrun, 1);
    wait_valid(lat);
    chk("set_wins_sig", $signed(sig), 3000);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;

    // Strobe coincident with sig_valid is accepted
    load('{1000, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0});
    strobe();
    wait_valid(lat);
    chk("coinc_first", $signed(sig), 1000);
    load('{-2500, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0});
    strobe();
    wait_valid(lat);
    chk("coinc_lat", lat, 6);
    chk("coinc_sig", $signed(sig), -2500);
    chk("coinc_no_overrun", overrun, 0);

    // Inputs changed after the strobe edge do not affect the mix
    load('{100, 200, 300, 400}, 4'b1111, '{128, 128, 128, 128});
    strobe();
    load('{7000, 7000, 7000, 7000}, 4'b0011, '{10, 10, 10, 10});
    wait_valid(lat);
    chk("snap_lat", lat, 6);
    chk("snap_sig", $signed(sig), 1000);

    // Reset mid-mix aborts with no result
    load('{1234, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0});
    strobe();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_sig", $signed(sig), 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", sig_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_valid(10, cnt, last);
    chk("abort_no_valid", cnt, 0);
    run_mix("after_abort", '{777, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0}, 777);

`ifdef VOICE_MIXER_PEAK_EN
    peak_clr = 1'b1;
    @(posedge clk); #1;
    peak_clr = 1'b0;
    chk("peak_clr0", peak, 0);
    run_mix("pk_neg", '{-20000, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0}, -20000);
    chk("peak_a", peak, 20000);
    run_mix("pk_pos", '{5000, 0, 0, 0}, 4'b0001, '{128, 0, 0, 0}, 5000);
    chk("peak_b", peak, 20000);
    peak_clr = 1'b1;
    @(posedge clk); #1;
    peak_clr = 1'b0;
    chk("peak_clr1", peak, 0);
    run_mix("pk_min", '{-30000, -30000, -30000, -30000}, 4'b1111, '{128, 128, 128, 128}, -32768);
    chk("peak_min", peak, 32767);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
